ahbl_dma_master: RTL and testbench

- Single-channel AHB-Lite initiator. It copies a block of 32-bit words from a source address to a destination address, one word at a time.
- It sits on the data fabric as a second bus master, alongside the core's data port. It reaches data_sram and the APB bridge through the same slave-side protocol those blocks already implement.
- Software, or a control-register wrapper, launches a copy through a valid/ready command port. Completion or bus error is reported on status outputs.

---
 rtl/ahbl_dma_master.sv | 163 ++++++++++++++++
 tb/tb_ahbl_dma_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_dma_master.sv
// Single-channel AHB-Lite DMA initiator: copies cmd_len 32-bit words from cmd_src to cmd_dst,
// one non-pipelined read/write pair per word, with sticky error reporting.
module ahbl_dma_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ADDR_WIDTH-1:0] ahbl_haddr,
  output logic [2:0]            ahbl_hburst,
  output logic                  ahbl_hmastlock,
  output logic [3:0]            ahbl_hprot,
  output logic [2:0]            ahbl_hsize,
  output logic [1:0]            ahbl_htrans,
  output logic [DATA_WIDTH-1:0] ahbl_hwdata,
  output logic                  ahbl_hwrite,
  input  logic [DATA_WIDTH-1:0] ahbl_hrdata,
  input  logic                  ahbl_hready,
  input  logic                  ahbl_hresp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_FINISH
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      buf_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      buf_q      <= buf_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    buf_d      = buf_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // Word-align by masking rather than slicing so every command bit is consumed.
          src_d   = cmd_src & ~ADDR_WIDTH'(3);
          dst_d   = cmd_dst & ~ADDR_WIDTH'(3);
          len_d   = cmd_len;
          err_d   = 1'b0;
          state_d = (cmd_len == '0) ? S_FINISH : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (ahbl_hready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (ahbl_hready) begin
          if (ahbl_hresp) begin
            err_d      = 1'b1;
            err_addr_d = src_q;
            state_d    = S_FINISH;
          end else begin
            buf_d   = ahbl_hrdata;
            state_d = S_WR_ADDR;
          end
        end
      end
      S_WR_ADDR: begin
        if (ahbl_hready) state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        if (ahbl_hready) begin
          if (ahbl_hresp) begin
            err_d      = 1'b1;
            err_addr_d = dst_q;
            state_d    = S_FINISH;
          end else begin
            len_d   = len_q - LEN_WIDTH'(1);
            src_d   = src_q + ADDR_WIDTH'(4);
            dst_d   = dst_q + ADDR_WIDTH'(4);
            state_d = (len_q == LEN_WIDTH'(1)) ? S_FINISH : S_RD_ADDR;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Address-phase signals are pure functions of state, so they hold naturally during wait states.
  always_comb begin
    ahbl_haddr  = '0;
    ahbl_htrans = HTRANS_IDLE;
    ahbl_hwrite = 1'b0;
    ahbl_hwdata = '0;
    case (state_q)
      S_RD_ADDR: begin
        ahbl_haddr  = src_q;
        ahbl_htrans = HTRANS_NONSEQ;
      end
      S_RD_DATA: ahbl_haddr = src_q;
      S_WR_ADDR: begin
        ahbl_haddr  = dst_q;
        ahbl_htrans = HTRANS_NONSEQ;
        ahbl_hwrite = 1'b1;
      end
      S_WR_DATA: begin
        ahbl_haddr  = dst_q;
        ahbl_hwdata = buf_q;
      end
      default: ;
    endcase
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done           = (state_q == S_FINISH);
  assign err            = err_q;
  assign err_addr       = err_addr_q;
  assign ahbl_hburst    = 3'b000;
  assign ahbl_hmastlock = 1'b0;
  assign ahbl_hprot     = 4'b0011;
  assign ahbl_hsize     = 3'b010;

endmodule

// File: tb/tb_ahbl_dma_master.sv
// Directed bench for ahbl_dma_master: behavioural AHB-Lite slave with configurable wait states
// and error injection; transfers and committed writes are scoreboarded against expected queues.
module tb_ahbl_dma_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_src = '0;
  logic [31:0] cmd_dst = '0;
  logic [15:0] cmd_len = '0;
  logic        busy, done, err;
  logic [31:0] err_addr;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [31:0] s_hrdata;
  logic        s_hready;
  logic        s_hresp;

  ahbl_dma_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .ahbl_haddr(haddr), .ahbl_hburst(hburst), .ahbl_hmastlock(hmastlock),
    .ahbl_hprot(hprot), .ahbl_hsize(hsize), .ahbl_htrans(htrans),
    .ahbl_hwdata(hwdata), .ahbl_hwrite(hwrite), .ahbl_hrdata(s_hrdata),
    .ahbl_hready(s_hready), .ahbl_hresp(s_hresp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave configuration and source memory, written only by the stimulus block.
  int          addr_wait = 0;
  int          data_wait = 0;
  bit          err_en = 1'b0;
  logic [31:0] err_at = '0;
  logic [31:0] src_mem [256];

  logic [32:0] obs_q [$];
  logic [32:0] exp_q [$];
  logic [63:0] wr_q [$];
  logic [63:0] exp_wr_q [$];

  logic        dp_active = 1'b0;
  logic        dp_write = 1'b0;
  logic        dp_err = 1'b0;
  logic [31:0] dp_addr = '0;
  int          aw_cnt = 0;
  int          dw_cnt = 0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_addr = '0;
  logic        hold_write = 1'b0;
  logic [31:0] hw_hold = '0;
  int          stab_viol = 0;

  always_comb begin
    s_hready = 1'b1;
    s_hresp  = 1'b0;
    s_hrdata = 32'hDEAD_BEEF;
    if (dp_active) begin
      if (dp_err) begin
        s_hresp  = 1'b1;
        s_hready = (dw_cnt >= 1);
      end else begin
        s_hready = (dw_cnt >= data_wait);
        if (!dp_write && s_hready) s_hrdata = src_mem[dp_addr[9:2]];
      end
    end else if (htrans == 2'b10) begin
      s_hready = (aw_cnt >= addr_wait);
    end
  end

  always @(posedge clk or posedge rst) begin : slave
    int v;
    v = 0;
    if (rst) begin
      dp_active  <= 1'b0;
      aw_cnt     <= 0;
      dw_cnt     <= 0;
      hold_valid <= 1'b0;
    end else if (dp_active) begin
      if (htrans !== 2'b00) v++;
      if (dp_write) begin
        if (dw_cnt > 0 && hwdata !== hw_hold) v++;
        hw_hold <= hwdata;
      end
      if (s_hready) begin
        if (dp_write && !dp_err) wr_q.push_back({dp_addr, hwdata});
        dp_active <= 1'b0;
        dw_cnt    <= 0;
      end else begin
        dw_cnt <= dw_cnt + 1;
      end
    end else if (htrans == 2'b10) begin
      if (hold_valid && (haddr !== hold_addr || hwrite !== hold_write)) v++;
      if (s_hready) begin
        obs_q.push_back({hwrite, haddr});
        dp_active  <= 1'b1;
        dp_write   <= hwrite;
        dp_addr    <= haddr;
        dp_err     <= err_en && hwrite && (haddr == err_at);
        aw_cnt     <= 0;
        hold_valid <= 1'b0;
      end else begin
        aw_cnt     <= aw_cnt + 1;
        hold_valid <= 1'b1;
        hold_addr  <= haddr;
        hold_write <= hwrite;
      end
    end else if (hold_valid) begin
      v++;
      hold_valid <= 1'b0;
      aw_cnt     <= 0;
    end
    stab_viol <= stab_viol + v;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    cmd_src = s; cmd_dst = d; cmd_len = n; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_src = 32'h0BAD_0000; cmd_dst = 32'h0BAD_0000; cmd_len = 16'h7777;
    @(negedge clk);
    e0 = cyc;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        lat = cyc - e0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, s + 32'(4 * i)});
      exp_q.push_back({1'b1, d + 32'(4 * i)});
      exp_wr_q.push_back({d + 32'(4 * i), src_mem[8'((s >> 2) + 32'(i))]});
    end
  endtask

  task automatic compare_queues(input string tag);
    check({tag, " xfer_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, " xfer"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    check({tag, " write_count"}, 64'(wr_q.size()), 64'(exp_wr_q.size()));
    while (wr_q.size() > 0 && exp_wr_q.size() > 0)
      check({tag, " write"}, wr_q.pop_front(), exp_wr_q.pop_front());
    obs_q.delete(); exp_q.delete(); wr_q.delete(); exp_wr_q.delete();
    check({tag, " bus_stability"}, 64'(stab_viol), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " haddr"}, 64'(haddr), 64'(0));
    check({tag, " htrans"}, 64'(htrans), 64'(0));
    check({tag, " hwrite"}, 64'(hwrite), 64'(0));
    check({tag, " hwdata"}, 64'(hwdata), 64'(0));
    check({tag, " busy"}, 64'(busy), 64'(0));
    check({tag, " done"}, 64'(done), 64'(0));
    check({tag, " err"}, 64'(err), 64'(0));
    check({tag, " err_addr"}, 64'(err_addr), 64'(0));
    check({tag, " cmd_ready"}, 64'(cmd_ready), 64'(1));
  endtask

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    for (int i = 0; i < 256; i++) src_mem[i] = 32'hC0DE_0000 | 32'(i);
    src_mem[64]  = 32'h11;
    src_mem[65]  = 32'h22;
    src_mem[66]  = 32'h33;
    src_mem[67]  = 32'h44;
    src_mem[255] = 32'hAA;
    src_mem[0]   = 32'hBB;

    // Reset state, with a command offered during reset that must not be taken.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 16'd3; cmd_src = 32'h100; cmd_dst = 32'h200;
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset consts", {hburst, hmastlock, hprot, hsize}, {3'b000, 1'b0, 4'b0011, 3'b010});
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset busy", 64'(busy), 64'(0));

    // 3-word copy, zero-wait slave.
    push_copy(32'h100, 32'h200, 3);
    start(32'h100, 32'h200, 16'd3);
    check("copy3 busy", 64'(busy), 64'(1));
    check("copy3 cmd_ready", 64'(cmd_ready), 64'(0));
    wait_done(100, lat);
    check("copy3 done_latency", 64'(lat), 64'(12));
    check("copy3 err", 64'(err), 64'(0));
    check("copy3 busy_at_done", 64'(busy), 64'(0));
    @(negedge clk);
    check("copy3 done_one_cycle", 64'(done), 64'(0));
    compare_queues("copy3");

    // Same copy with address and data wait states.
    addr_wait = 1; data_wait = 2;
    push_copy(32'h100, 32'h200, 3);
    start(32'h103, 32'h202, 16'd3);
    wait_done(200, lat);
    check("wait done_latency", 64'(lat), 64'(30));
    check("wait err", 64'(err), 64'(0));
    @(negedge clk);
    check("wait done_one_cycle", 64'(done), 64'(0));
    compare_queues("wait");
    addr_wait = 0; data_wait = 0;

    // Bus error on the second write; the failing write is not committed.
    err_en = 1'b1; err_at = 32'h204;
    exp_q.push_back({1'b0, 32'h100});
    exp_q.push_back({1'b1, 32'h200});
    exp_q.push_back({1'b0, 32'h104});
    exp_q.push_back({1'b1, 32'h204});
    exp_wr_q.push_back({32'h200, 32'h11});
    start(32'h100, 32'h200, 16'd4);
    wait_done(100, lat);
    check("berr done_latency", 64'(lat), 64'(9));
    check("berr err", 64'(err), 64'(1));
    check("berr err_addr", 64'(err_addr), 64'(32'h204));
    repeat (6) begin
      @(negedge clk);
      check("berr no_second_done", 64'(done), 64'(0));
    end
    check("berr err_sticky", 64'(err), 64'(1));
    compare_queues("berr");
    err_en = 1'b0;

    // Zero-length command clears err and finishes with no bus activity.
    start(32'h100, 32'h200, 16'd0);
    check("len0 htrans", 64'(htrans), 64'(0));
    wait_done(10, lat);
    check("len0 done_latency", 64'(lat), 64'(0));
    check("len0 err_cleared", 64'(err), 64'(0));
    @(negedge clk);
    check("len0 done_one_cycle", 64'(done), 64'(0));
    compare_queues("len0");

    // Command offered while busy is ignored.
    push_copy(32'h100, 32'h200, 2);
    start(32'h100, 32'h200, 16'd2);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_src = 32'h140; cmd_dst = 32'h240; cmd_len = 16'd5;
    check("busy cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(100, lat);
    check("busy done_latency", 64'(lat), 64'(8));
    repeat (4) @(negedge clk);
    check("busy stays_idle", 64'(busy), 64'(0));
    compare_queues("busy");

    // Address wrap-around, then reset during the second read's data phase.
    exp_q.push_back({1'b0, 32'hFFFF_FFFC});
    exp_q.push_back({1'b1, 32'h300});
    exp_q.push_back({1'b0, 32'h0000_0000});
    exp_wr_q.push_back({32'h300, 32'hAA});
    start(32'hFFFF_FFFC, 32'h300, 16'd2);
    repeat (5) @(negedge clk);
    check("wrap third_xfer_seen", 64'(obs_q.size()), 64'(3));
    check("wrap in_data_phase", 64'(htrans), 64'(0));
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("abort no_done", 64'(done), 64'(0));
    end
    check("abort busy", 64'(busy), 64'(0));
    check("abort htrans", 64'(htrans), 64'(0));
    compare_queues("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
